// File: rtl/bmult_pkg.sv
// Shared types for the bitheap multiplier scheduler and its result FIFO.
package bmult_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 2 * OP_W;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned ID_W   = 3;

    typedef logic [PROD_W-1:0] prod_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        prod_t           prod;
    } res_entry_t;

endpackage

// File: rtl/bmult_res_fifo.sv
// Result FIFO: stores {requester id, product} in issue order with a registered count.
module bmult_res_fifo
    import bmult_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  res_entry_t       i_data,
    input  logic             i_pop,
    output res_entry_t       o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    res_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            // Cleared so the read port shows zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));

endmodule

// File: rtl/bmult_rr_scheduler.sv
// Round-robin front end sharing one pipelined 16x16 multiplier among N_REQ requesters,
// returning products in acceptance order through a credit-protected result FIFO.
module bmult_rr_scheduler
    import bmult_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MULT_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*OP_W-1:0]    i_req_a,
    input  logic [N_REQ*OP_W-1:0]    i_req_b,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_mul_issue,
    output logic [OP_W-1:0]          o_mul_a,
    output logic [OP_W-1:0]          o_mul_b,
    input  logic [PROD_W:0]          i_mul_p,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [PROD_W-1:0]        o_res_data,
    output logic [$clog2(N_REQ)-1:0] o_res_id
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_inflight;
    logic             r_issue;
    logic [PTR_W-1:0] r_issue_tag;
    logic [OP_W-1:0]  r_mul_a;
    logic [OP_W-1:0]  r_mul_b;
    logic             r_tag_vld [MULT_LAT];
    logic [PTR_W-1:0] r_tag     [MULT_LAT];

    logic [OP_W-1:0]  w_req_a [N_REQ];
    logic [OP_W-1:0]  w_req_b [N_REQ];
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_gnt;
    logic             w_found;
    logic             w_credit;
    logic             w_accept;
    logic             w_exit;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_occ;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    res_entry_t       w_push_entry;
    res_entry_t       w_rd_entry;
    logic             w_unused;

    for (genvar i = 0; i < N_REQ; i++) begin : g_ops
        assign w_req_a[i] = i_req_a[i*OP_W +: OP_W];
        assign w_req_b[i] = i_req_b[i*OP_W +: OP_W];
    end

    // Pops in the current cycle are deliberately not credited back.
    assign w_occ    = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_credit = (w_occ < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_accept    = i_rst_n && w_found && w_credit;
    assign o_req_ready = w_accept ? (N_REQ'(1) << w_gnt) : '0;

    assign w_exit            = r_tag_vld[MULT_LAT-1];
    assign w_push_entry.id   = ID_W'(r_tag[MULT_LAT-1]);
    assign w_push_entry.prod = i_mul_p[PROD_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_inflight  <= '0;
            r_issue     <= 1'b0;
            r_issue_tag <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag[i]     <= '0;
            end
        end else begin
            r_issue <= w_accept;
            if (w_accept) begin
                r_issue_tag <= w_gnt;
                r_mul_a     <= w_req_a[w_gnt];
                r_mul_b     <= w_req_b[w_gnt];
                r_ptr       <= (w_gnt == PTR_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
            end
            // Issue register plus MULT_LAT stages lines the tag up with mul_p.
            r_tag_vld[0] <= r_issue;
            r_tag[0]     <= r_issue_tag;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag[i]     <= r_tag[i-1];
            end
            case ({w_accept, w_exit})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    bmult_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_exit),
        .i_data  (w_push_entry),
        .i_pop   (o_res_valid && i_res_ready),
        .o_data  (w_rd_entry),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_mul_issue = r_issue;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_res_valid = !w_fifo_empty;
    assign o_res_data  = w_rd_entry.prod;
    assign o_res_id    = w_rd_entry.id[PTR_W-1:0];

    // Product MSB from the multiplier is garbage by contract.
    assign w_unused = ^{i_mul_p[PROD_W], w_rd_entry.id, w_fifo_full};

    a_occ_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_occ <= (CNT_W+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_bmult_rr_scheduler.sv
// Randomized scoreboard bench for bmult_rr_scheduler against a queue-based reference model.
module tb_bmult_rr_scheduler;

    localparam int unsigned N_REQ      = 4;
    localparam int unsigned MULT_LAT   = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned OP_W       = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [N_REQ-1:0]          req_valid = '0;
    logic [N_REQ*OP_W-1:0]     req_a = '0;
    logic [N_REQ*OP_W-1:0]     req_b = '0;
    logic [N_REQ-1:0]          req_ready;
    logic                      mul_issue;
    logic [OP_W-1:0]           mul_a;
    logic [OP_W-1:0]           mul_b;
    logic [2*OP_W:0]           mul_p;
    logic                      res_valid;
    logic                      res_ready = 1'b0;
    logic [2*OP_W-1:0]         res_data;
    logic [$clog2(N_REQ)-1:0]  res_id;

    always #5 clk = ~clk;

    bmult_rr_scheduler #(
        .N_REQ      (N_REQ),
        .MULT_LAT   (MULT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_mul_issue (mul_issue),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .i_mul_p     (mul_p),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_res_id    (res_id)
    );

    // External multiplier: MULT_LAT registered stages, MSB and idle cycles carry garbage.
    logic [2*OP_W:0] m_pipe [MULT_LAT];
    always @(posedge clk) begin
        if (mul_issue) m_pipe[0] <= {1'($urandom), 32'(mul_a) * 32'(mul_b)};
        else           m_pipe[0] <= 33'({$urandom, $urandom});
        for (int i = 1; i < MULT_LAT; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign mul_p = m_pipe[MULT_LAT-1];

    int n_chk = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int unsigned id;
        logic [31:0] prod;
        int          avail;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    bit          pop_pending = 0;
    int unsigned mptr = 0;
    bit          exp_issue = 0;
    logic [15:0] exp_a, exp_b;
    int          hs_cnt = 0;
    int unsigned glog[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) n_pop <= 0;
        else        n_pop <= n_pop + int'(pop_pending);
    end

    // Stimulus-side model: predicts grant, credit and issue; pushes expected results.
    always @(negedge clk) begin
        int g;
        logic [N_REQ-1:0] exp_ready;
        logic [15:0] a, b;
        if (!rst_n) begin
            n_acc = 0;
            mptr = 0;
            exp_issue = 0;
            sb.delete();
        end else begin
            check("mul_issue", mul_issue, exp_issue);
            if (exp_issue) begin
                check("mul_a", mul_a, exp_a);
                check("mul_b", mul_b, exp_b);
            end
            g = -1;
            if (n_acc - n_pop < int'(FIFO_DEPTH)) begin
                for (int k = 0; k < N_REQ; k++) begin
                    int idx;
                    idx = int'((mptr + k) % N_REQ);
                    if (req_valid[idx]) begin
                        g = idx;
                        break;
                    end
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            exp_issue = (g >= 0);
            if (g >= 0) begin
                a = req_a[g*OP_W +: OP_W];
                b = req_b[g*OP_W +: OP_W];
                exp_a = a;
                exp_b = b;
                sb.push_back('{id: g, prod: 32'(a) * 32'(b), avail: cyc + 2 + int'(MULT_LAT)});
                n_acc++;
                mptr = (g + 1) % N_REQ;
            end
        end
    end

    // Result monitor: pops the scoreboard whenever the model says a result is presented.
    always @(negedge clk) begin
        bit ev;
        if (!rst_n) begin
            pop_pending = 0;
        end else begin
            ev = (sb.size() > 0) && (sb[0].avail <= cyc);
            check("res_valid", res_valid, ev);
            if (ev) begin
                check("res_data", res_data, sb[0].prod);
                check("res_id", res_id, sb[0].id);
            end
            pop_pending = ev && res_ready;
            if (pop_pending) void'(sb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_cnt++;
                    glog.push_back(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        res_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*OP_W +: OP_W] = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            req_b[i*OP_W +: OP_W] = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_mul_issue"}, mul_issue, 1'b0);
        check({tag, "_mul_a"}, mul_a, 16'h0);
        check({tag, "_mul_b"}, mul_b, 16'h0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_data"}, res_data, 32'h0);
        check({tag, "_res_id"}, res_id, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int hs0;
        // Reset, with requesters valid to confirm ready stays low.
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single request from requester 2 with all-ones operands.
        res_ready = 1'b1;
        req_a[2*OP_W +: OP_W] = 16'hFFFF;
        req_b[2*OP_W +: OP_W] = 16'hFFFF;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < 20);
        check("single_latency", k, MULT_LAT + 2);
        check("single_data", res_data, 32'hFFFE0001);
        check("single_id", res_id, 2);
        drain(6);

        // All requesters valid, consumer always ready.
        req_valid = '1;
        for (int i = 0; i < 24; i++) begin
            rand_ops();
            tick();
        end
        drain(6);

        // Consumer stalled: exactly FIFO_DEPTH accepts, then resume.
        res_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        hs0 = hs_cnt;
        repeat (10) tick();
        check("stall_accepts", hs_cnt - hs0, FIFO_DEPTH);
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            tick();
        end
        drain(8);

        // Park pointer at 2, then only requesters 1 and 3 valid.
        req_valid = 4'b0010;
        tick();
        drain(6);
        res_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*OP_W +: OP_W] = 16'h1234;
            req_b[i*OP_W +: OP_W] = 16'h0010;
        end
        glog.delete();
        req_valid = 4'b1010;
        repeat (3) tick();
        req_valid = '0;
        check("pair_grants", glog.size(), 3);
        if (glog.size() == 3) begin
            check("pair_g0", glog[0], 3);
            check("pair_g1", glog[1], 1);
            check("pair_g2", glog[2], 3);
        end
        k = 0;
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pair_data", res_data, 32'h00012340);
        check("pair_id", res_id, 3);
        drain(8);

        // Reset with two operations in flight and one result queued.
        res_ready = 1'b0;
        req_valid = '1;
        rand_ops();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (8) tick();

        // Random traffic with random backpressure.
        for (int i = 0; i < 20000; i++) begin
            req_valid = N_REQ'($urandom);
            rand_ops();
            res_ready = ($urandom_range(3) != 0);
            tick();
        end
        drain(12);
        check("final_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
